// File: rtl/lsu_cmpl_arbiter_if.sv
// Bundle of the load-finish, side-report and ROB completion signals around the
// LSU completion arbiter; master is the pipeline/ROB side, slave is the arbiter.
interface lsu_cmpl_arbiter_if #(
    parameter int ID_W = 7
);
    logic            flush;
    logic            ld_valid;
    logic [ID_W-1:0] ld_id;
    logic            ld_stall;
    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_id;
    logic            req_ls;
    logic            req_ex;
    logic [31:0]     req_bad_addr;
    logic            rob_valid;
    logic [ID_W-1:0] rob_id;
    logic            rob_ls;
    logic            rob_set_ex;
    logic [31:0]     rob_bad_addr;

    modport master (
        output flush, ld_valid, ld_id, req_valid, req_id, req_ls, req_ex, req_bad_addr,
        input  ld_stall, req_ready, rob_valid, rob_id, rob_ls, rob_set_ex, rob_bad_addr
    );

    modport slave (
        input  flush, ld_valid, ld_id, req_valid, req_id, req_ls, req_ex, req_bad_addr,
        output ld_stall, req_ready, rob_valid, rob_id, rob_ls, rob_set_ex, rob_bad_addr
    );
endinterface

// File: rtl/lsu_cmpl_arbiter.sv
// Arbitrates the single registered ROB completion port between load-finish reports
// (priority) and FIFO-buffered side reports, with a wait counter bounding starvation.
module lsu_cmpl_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3,
    parameter int ID_W     = 7
) (
    input logic                clk,
    input logic                rst,
    lsu_cmpl_arbiter_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] MAXW_C  = WAIT_W'(MAX_WAIT);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            ls;
        logic            ex;
        logic [31:0]     addr;
    } rpt_t;

    rpt_t              mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              rob_valid_q, rob_valid_d;
    rpt_t              rob_q, rob_d;

    logic fifo_empty, accept, ld_go, pop, bypass, push;
    rpt_t req_rpt, sel_rpt;

    assign fifo_empty   = (cnt_q == '0);
    assign bus.req_ready = (cnt_q < DEPTH_C);
    assign bus.ld_stall  = !fifo_empty && (wait_q == MAXW_C);

    assign req_rpt = '{id: bus.req_id, ls: bus.req_ls, ex: bus.req_ex, addr: bus.req_bad_addr};

    always_comb begin
        accept = bus.req_valid && bus.req_ready;
        ld_go  = !bus.flush && bus.ld_valid && !bus.ld_stall;
        pop    = !bus.flush && !ld_go && !fifo_empty;
        bypass = !bus.flush && !ld_go && fifo_empty && accept;
        push   = !bus.flush && accept && !bypass;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        rob_valid_d = 1'b0;
        rob_d       = rob_q;
        sel_rpt     = pop ? mem_q[rd_ptr_q] : req_rpt;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            wait_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
            // Counter only ages an entry that was already waiting at this edge.
            if (pop || fifo_empty)   wait_d = '0;
            else if (wait_q != MAXW_C) wait_d = wait_q + WAIT_W'(1);

            if (ld_go) begin
                rob_valid_d = 1'b1;
                rob_d       = '{id: bus.ld_id, ls: 1'b0, ex: 1'b0, addr: 32'h0};
            end else if (pop || bypass) begin
                rob_valid_d = 1'b1;
                rob_d       = sel_rpt;
                rob_d.ls    = sel_rpt.ls && sel_rpt.ex;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            rob_valid_q <= 1'b0;
            rob_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            rob_valid_q <= rob_valid_d;
            rob_q       <= rob_d;
        end
    end

    // FIFO storage holds only payload; occupancy is tracked by the reset pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= req_rpt;
    end

    assign bus.rob_valid    = rob_valid_q;
    assign bus.rob_id       = rob_q.id;
    assign bus.rob_ls       = rob_q.ls;
    assign bus.rob_set_ex   = rob_q.ex;
    assign bus.rob_bad_addr = rob_q.addr;
endmodule

// File: tb/tb_lsu_cmpl_arbiter.sv
// Directed bench for lsu_cmpl_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_lsu_cmpl_arbiter;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;
    localparam int ID_W     = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_cmpl_arbiter_if #(.ID_W(ID_W)) bus ();

    lsu_cmpl_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic            ls;
        logic            ex;
        logic [31:0]     addr;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t            mq[$];
    int              m_wait;
    logic            m_rv;
    logic [ID_W-1:0] m_id;
    logic            m_ls;
    logic            m_ex;
    logic [31:0]     m_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        return (mq.size() != 0) && (m_wait == MAX_WAIT);
    endfunction

    function automatic bit m_ready();
        return mq.size() < DEPTH;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_wait = 0;
        m_rv = 1'b0; m_id = '0; m_ls = 1'b0; m_ex = 1'b0; m_addr = '0;
    endtask

    task automatic m_emit(input ent_t e);
        m_rv   = 1'b1;
        m_id   = e.id;
        m_ex   = e.ex;
        m_ls   = e.ex ? e.ls : 1'b0;
        m_addr = e.addr;
    endtask

    // Apply one clock edge worth of arbitration rules to the model.
    task automatic m_step();
        int   sz;
        bit   acc;
        ent_t e;
        ent_t h;
        sz  = mq.size();
        acc = bus.req_valid && m_ready();
        e   = '{bus.req_id, bus.req_ls, bus.req_ex, bus.req_bad_addr};
        if (bus.flush) begin
            m_rv = 1'b0;
            mq.delete();
            m_wait = 0;
        end else if (bus.ld_valid && !m_stall()) begin
            m_rv = 1'b1; m_id = bus.ld_id; m_ls = 1'b0; m_ex = 1'b0; m_addr = '0;
            if (acc) mq.push_back(e);
            if (sz == 0) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
        end else if (sz != 0) begin
            h = mq.pop_front();
            m_emit(h);
            if (acc) mq.push_back(e);
            m_wait = 0;
        end else if (acc) begin
            m_emit(e);
            m_wait = 0;
        end else begin
            m_rv = 1'b0;
            m_wait = 0;
        end
    endtask

    task automatic check_all();
        chk("ld_stall",     32'(bus.ld_stall),     32'(m_stall()));
        chk("req_ready",    32'(bus.req_ready),    32'(m_ready()));
        chk("rob_valid",    32'(bus.rob_valid),    32'(m_rv));
        chk("rob_id",       32'(bus.rob_id),       32'(m_id));
        chk("rob_ls",       32'(bus.rob_ls),       32'(m_ls));
        chk("rob_set_ex",   32'(bus.rob_set_ex),   32'(m_ex));
        chk("rob_bad_addr", bus.rob_bad_addr,      m_addr);
    endtask

    task automatic tick();
        if (rst) m_reset();
        else     m_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_req(input bit v, input logic [ID_W-1:0] id, input bit ls,
                           input bit ex, input logic [31:0] addr);
        bus.req_valid = v; bus.req_id = id; bus.req_ls = ls; bus.req_ex = ex; bus.req_bad_addr = addr;
    endtask

    ent_t            got[$];
    logic [ID_W-1:0] lid;
    logic [ID_W-1:0] rid;
    bit              acc_l;
    bit              acc_r;
    bit              saw_nr;

    initial begin
        bus.flush = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_id = '0;
        set_req(1'b0, '0, 1'b0, 1'b0, 32'h0);
        m_reset();

        // Reset / idle
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_rob_valid", 32'(bus.rob_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_ld_stall",  32'(bus.ld_stall),  32'd0);
        chk("rst_rob_addr",  bus.rob_bad_addr,   32'h0);

        // Load only, back to back
        bus.ld_valid = 1'b1; bus.ld_id = 7'h12;
        tick();
        chk("ld0_valid", 32'(bus.rob_valid), 32'd1);
        chk("ld0_id",    32'(bus.rob_id),    32'h12);
        chk("ld0_ex",    32'(bus.rob_set_ex), 32'd0);
        bus.ld_id = 7'h13;
        tick();
        chk("ld1_id", 32'(bus.rob_id), 32'h13);
        bus.ld_valid = 1'b0;
        tick();
        chk("ld_idle", 32'(bus.rob_valid), 32'd0);

        // Bypass with exception
        set_req(1'b1, 7'h05, 1'b1, 1'b1, 32'h8000_0003);
        tick();
        chk("byp_valid", 32'(bus.rob_valid),  32'd1);
        chk("byp_id",    32'(bus.rob_id),     32'h05);
        chk("byp_ex",    32'(bus.rob_set_ex), 32'd1);
        chk("byp_ls",    32'(bus.rob_ls),     32'd1);
        chk("byp_addr",  bus.rob_bad_addr,    32'h8000_0003);
        chk("byp_ready", 32'(bus.req_ready),  32'd1);
        set_req(1'b0, '0, 1'b0, 1'b0, 32'h0);
        tick();

        // Starvation: continuous loads, one side report with ex=0 (ls forced low)
        lid = 7'h40;
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.ld_id = lid;
            if (i == 0) set_req(1'b1, 7'h20, 1'b1, 1'b0, 32'h0000_1234);
            else        set_req(1'b0, '0, 1'b0, 1'b0, 32'h0);
            acc_l = !m_stall();
            tick();
            if (acc_l) lid = lid + 7'd1;
            if (i == 3) chk("starve_stall", 32'(bus.ld_stall), 32'd1);
            if (i == 4) begin
                chk("starve_pop_id", 32'(bus.rob_id),   32'h20);
                chk("starve_pop_ls", 32'(bus.rob_ls),   32'd0);
                chk("starve_unstal", 32'(bus.ld_stall), 32'd0);
            end
            if (i == 5) chk("starve_resume", 32'(bus.rob_id), 32'h44);
        end
        bus.ld_valid = 1'b0;
        tick();

        // Full / backpressure: continuous loads, side ids 1..5
        lid = 7'h50; rid = 7'd1; saw_nr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.ld_valid = (i < 20);
            bus.ld_id = lid;
            if (rid <= 7'd5) set_req(1'b1, rid, 1'b0, 1'b1, {25'h0, rid});
            else             set_req(1'b0, '0, 1'b0, 1'b0, 32'h0);
            acc_l = bus.ld_valid && !m_stall();
            acc_r = bus.req_valid && m_ready();
            if (bus.req_valid && !m_ready()) saw_nr = 1'b1;
            tick();
            if (acc_l) lid = lid + 7'd1;
            if (acc_r) rid = rid + 7'd1;
            if (bus.rob_valid && bus.rob_id >= 7'd1 && bus.rob_id <= 7'd5)
                got.push_back('{bus.rob_id, bus.rob_ls, bus.rob_set_ex, bus.rob_bad_addr});
        end
        chk("full_saw_notready", 32'(saw_nr), 32'd1);
        chk("full_out_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) chk("full_order", 32'(got[i].id), 32'(i + 1));
            else                chk("full_missing", 32'd0, 32'(i + 1));
        end

        // Flush with two queued entries and a load present
        bus.ld_valid = 1'b1; bus.ld_id = 7'h70;
        set_req(1'b1, 7'h0A, 1'b0, 1'b0, 32'h0);
        tick();
        bus.ld_id = 7'h71;
        set_req(1'b1, 7'h0B, 1'b0, 1'b0, 32'h0);
        tick();
        bus.flush = 1'b1; bus.ld_id = 7'h72;
        tick();
        chk("flush_valid", 32'(bus.rob_valid), 32'd0);
        chk("flush_ready", 32'(bus.req_ready), 32'd1);
        chk("flush_stall", 32'(bus.ld_stall),  32'd0);
        bus.flush = 1'b0; bus.ld_valid = 1'b0;
        set_req(1'b1, 7'h31, 1'b0, 1'b1, 32'hDEAD_BEE0);
        tick();
        chk("postflush_valid", 32'(bus.rob_valid),  32'd1);
        chk("postflush_id",    32'(bus.rob_id),     32'h31);
        chk("postflush_ex",    32'(bus.rob_set_ex), 32'd1);
        chk("postflush_ls",    32'(bus.rob_ls),     32'd0);
        set_req(1'b0, '0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("postflush_idle", 32'(bus.rob_valid), 32'd0);

        // Reset mid-traffic with three entries queued
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ld_id = 7'h60 + 7'(i);
            set_req(1'b1, 7'h61 + 7'(i), 1'b1, 1'b1, 32'h100 + 32'(i));
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.rob_valid), 32'd0);
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_stall", 32'(bus.ld_stall),  32'd0);
        m_reset();
        bus.ld_valid = 1'b0;
        set_req(1'b0, '0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_nostale", 32'(bus.rob_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/lsu_cmpl_arbiter.md
Name: lsu_cmpl_arbiter

Overview:
- Shares the single LSU→ROB completion port between two sources: load-finish reports from the load pipe, and side reports (store completion, store/load address-error exceptions) from the address stage.
- Load-finish has priority. Side reports are buffered in a small FIFO, so the address stage stalls only when the FIFO is full.
- A wait counter bounds starvation of side reports by stalling the load pipe.
- The ROB port is registered.

Parameters:
- DEPTH, 4, side-report FIFO entries (power of 2, ≥2)
- MAX_WAIT, 3, cycles a non-empty FIFO head may be bypassed before ld_stall is asserted (≥1)
- ID_W, 7, ROB id width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; discards all pending reports
- ld_valid  in  1  load-finish report valid (held by load pipe while ld_stall)
- ld_id  in  ID_W  ROB id of finished load
- ld_stall  out  1  load pipe must hold its report this cycle
- req_valid  in  1  side report valid
- req_ready  out  1  side report accepted this cycle
- req_id  in  ID_W  ROB id
- req_ls  in  1  exception type: 1 = store address error, 0 = load address error
- req_ex  in  1  report carries an exception
- req_bad_addr  in  32  faulting address
- rob_valid  out  1  completion to ROB
- rob_id  out  ID_W
- rob_ls  out  1
- rob_set_ex  out  1
- rob_bad_addr  out  32

Behaviour:
- Reset values:
  - FIFO empty; count = 0; wait counter = 0.
  - rob_valid = 0, rob_id = 0, rob_ls = 0, rob_set_ex = 0, rob_bad_addr = 0.
  - ld_stall = 0; req_ready = 1 (combinational from cleared state).
  - Reset mid-operation drops every pending report.
- req_ready = (count < DEPTH). It uses the registered count, so it is low when the FIFO is full even if a pop occurs that cycle.
- ld_stall = (count != 0) && (wait == MAX_WAIT). It is a registered-state decode, not a function of the inputs.
- Output register, one selection per rising edge, in strict priority:
  1. flush → rob_valid <= 0; FIFO cleared; wait <= 0; inputs that cycle discarded.
  2. ld_valid && !ld_stall → load report: rob_valid=1, rob_id=ld_id, rob_set_ex=0, rob_ls=0, rob_bad_addr=0.
  3. count != 0 → pop head into the output register.
  4. req_valid && req_ready && FIFO empty → bypass directly into the output register (not enqueued).
  5. Otherwise → rob_valid <= 0; data fields hold their last value.
- Enqueue: req_valid && req_ready && not bypassed && !flush → push {id, ls, ex, bad_addr}.
  - Push and pop in the same cycle are both legal; count is unchanged.
- Latency:
  - Load report: 1 cycle (ld_valid at edge t → rob_valid high after edge t).
  - Side report: ≥1 cycle.
- ROB field mapping for a side report: rob_set_ex = req_ex; rob_ls = req_ls; rob_bad_addr = req_bad_addr. rob_ls is forced to 0 when ex = 0.
- Wait counter:
  - Resets to 0 on pop, flush, or when count == 0.
  - Otherwise increments by 1 per cycle while count != 0 and no pop, saturating at MAX_WAIT.
  - While saturated, ld_stall = 1, which forces a pop at the next edge.
- Ordering: side reports exit in arrival order. The bypass path is taken only when the FIFO is empty, so it never reorders.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

Test Plan:
- Reset/idle: assert rst mid-traffic with 3 entries queued → immediately rob_valid=0, req_ready=1, ld_stall=0. After release, no stale report appears.
- Load-only: ld_valid=1, ld_id=0x12 at edge 1 → after edge 1: rob_valid=1, rob_id=0x12, rob_set_ex=0. Back-to-back loads 0x12, 0x13 produce consecutive completions.
- Bypass: FIFO empty, ld_valid=0, req id=0x05, ex=1, ls=1, bad_addr=0x8000_0003 → next cycle rob_valid=1, rob_id=0x05, rob_set_ex=1, rob_ls=1, rob_bad_addr=0x8000_0003. count stays 0.
- Starvation (MAX_WAIT=3): ld_valid held high continuously, one side report id=0x20 enqueued → ld_stall rises after 3 bypassed cycles. The next edge emits id=0x20, then ld_stall drops and loads resume. No load report is lost or duplicated.
- Full/backpressure (DEPTH=4): continuous loads, side reports ids 1..5 → ids 1–4 accepted, req_ready=0 for id 5 until count < 4. Output order is 1, 2, 3, 4, 5.
- Flush: 2 entries queued and ld_valid=1 with flush=1 → next cycle rob_valid=0, count=0, wait=0. A new req id=0x31 the following cycle bypasses normally.
